// File: rtl/raw10_encoder_if.sv
// raw10_encoder_if
//   Handshake bundle around the RAW10 packer.
//   Input side : frame_active, data_in[IN_DATA_WIDTH], in_valid  -> in_ready
//   Output side: data_out[OUT_DATA_WIDTH], out_valid            <- out_ready
//   modport slave  : the encoder itself
//   modport master : whoever feeds pixel groups and consumes byte pairs
interface raw10_encoder_if #(
  parameter int IN_DATA_WIDTH  = 64,
  parameter int OUT_DATA_WIDTH = 16
);
  logic                      frame_active;
  logic [IN_DATA_WIDTH-1:0]  data_in;
  logic                      in_valid;
  logic                      in_ready;
  logic [OUT_DATA_WIDTH-1:0] data_out;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  frame_active, data_in, in_valid, out_ready,
    output in_ready, data_out, out_valid
  );

  modport master (
    output frame_active, data_in, in_valid, out_ready,
    input  in_ready, data_out, out_valid
  );
endinterface

// File: rtl/raw10_encoder.sv
// raw10_encoder
//   Packs pairs of 4-pixel groups (10-bit pixels in 16-bit slots) into the
//   five 16-bit RAW10 byte pairs of a CSI-2 lane, byte1 in [15:8].
//   Ports:
//     txbyteclkhs  byte clock, all registers update on its rising edge
//     reset_n      synchronous active-low reset
//     bus          raw10_encoder_if.slave: frame_active/data_in/in_valid/in_ready
//                  on the pixel side, data_out/out_valid/out_ready on the lane side
//   Only IN_DATA_WIDTH = 64 and OUT_DATA_WIDTH = 16 are meaningful.
module raw10_encoder #(
  parameter int IN_DATA_WIDTH  = 64,
  parameter int OUT_DATA_WIDTH = 16
) (
  input  logic                  txbyteclkhs,
  input  logic                  reset_n,
  raw10_encoder_if.slave        bus
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // await group A
    S1 = 3'd1,
    S2 = 3'd2,  // await group B (or end of line)
    S3 = 3'd3,
    S4 = 3'd4
  } state_t;

  state_t                    state, state_nxt;
  logic [OUT_DATA_WIDTH-1:0] data_p1, data_nxt;
  logic                      vld_p1, vld_nxt;
  logic [3:0][9:0]           grp_a, grp_a_nxt;
  logic [3:0][9:0]           grp_b, grp_b_nxt;

  logic [IN_DATA_WIDTH-1:0]  din;
  logic [3:0][9:0]           in_px;
  logic                      advance;
  logic                      in_ready_c;
  logic                      accept;
  logic                      unused_slot_bits;

  function automatic logic [7:0] hb(input logic [9:0] p);
    return p[9:2];
  endfunction

  function automatic logic [7:0] lsb(input logic [3:0][9:0] g);
    return {g[3][1:0], g[2][1:0], g[1][1:0], g[0][1:0]};
  endfunction

  assign din = bus.data_in;

  // Upper six bits of every 16-bit slot carry no pixel information.
  assign unused_slot_bits = ^{din[63:58], din[47:42], din[31:26], din[15:10]};

  always_comb begin
    in_px = '0;
    for (int k = 0; k < 4; k++) begin
      in_px[k] = din[16*k +: 10];
    end
  end

  // The output register may only move when it is empty or being drained.
  assign advance    = ~vld_p1 | bus.out_ready;
  // Gated by reset_n so nothing is advertised while reset is held.
  assign in_ready_c = reset_n & bus.frame_active & advance &
                      ((state == S0) | (state == S2));
  assign accept     = bus.in_valid & in_ready_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.data_out  = data_p1;
  assign bus.out_valid = vld_p1;

  always_comb begin
    state_nxt = state;
    data_nxt  = data_p1;
    vld_nxt   = vld_p1;
    grp_a_nxt = grp_a;
    grp_b_nxt = grp_b;
    if (advance) begin
      unique case (state)
        S0: begin
          if (accept) begin
            grp_a_nxt = in_px;
            data_nxt  = {hb(in_px[0]), hb(in_px[1])};
            vld_nxt   = 1'b1;
            state_nxt = S1;
          end else begin
            vld_nxt   = 1'b0;
          end
        end
        S1: begin
          data_nxt  = {hb(grp_a[2]), hb(grp_a[3])};
          vld_nxt   = 1'b1;
          state_nxt = S2;
        end
        S2: begin
          if (accept) begin
            grp_b_nxt = in_px;
            data_nxt  = {lsb(grp_a), hb(in_px[0])};
            vld_nxt   = 1'b1;
            state_nxt = S3;
          end else if (!bus.frame_active) begin
            // End of line with an odd group count: pad B with black pixels
            // so the line still closes on a 5-word boundary.
            grp_b_nxt = '0;
            data_nxt  = {lsb(grp_a), 8'h00};
            vld_nxt   = 1'b1;
            state_nxt = S3;
          end else begin
            vld_nxt   = 1'b0;
          end
        end
        S3: begin
          data_nxt  = {hb(grp_b[1]), hb(grp_b[2])};
          vld_nxt   = 1'b1;
          state_nxt = S4;
        end
        S4: begin
          data_nxt  = {hb(grp_b[3]), lsb(grp_b)};
          vld_nxt   = 1'b1;
          state_nxt = S0;
        end
        default: begin
          vld_nxt   = 1'b0;
          state_nxt = S0;
        end
      endcase
    end
  end

  // Output stage: registered byte pair, no combinational path from data_in.
  always_ff @(posedge txbyteclkhs) begin
    if (!reset_n) begin
      state   <= S0;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      grp_a   <= '0;
      grp_b   <= '0;
    end else begin
      state   <= state_nxt;
      vld_p1  <= vld_nxt;
      data_p1 <= data_nxt;
      grp_a   <= grp_a_nxt;
      grp_b   <= grp_b_nxt;
    end
  end

endmodule
